// File: rtl/z_core_mem_bridge_if.sv
// Core-side and memory-side signal bundle for the load/store bridge.
// The slave modport is the bridge's view; master is the core/memory environment.
interface z_core_mem_bridge_if;
    logic        core_req;
    logic        core_we;
    logic [1:0]  core_size;
    logic        core_unsigned;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic [31:0] core_rdata;
    logic        core_ready;
    logic        core_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport slave (
        input  core_req, core_we, core_size, core_unsigned, core_addr, core_wdata,
        input  mem_rdata, mem_ack,
        output core_rdata, core_ready, core_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output core_req, core_we, core_size, core_unsigned, core_addr, core_wdata,
        output mem_rdata, mem_ack,
        input  core_rdata, core_ready, core_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/z_core_mem_bridge.sv
// Load/store unit: byte/half/word accesses from the core onto a word-wide ack memory.
// Sub-word stores use read-modify-write; misalignment and ack timeouts complete with an error.
module z_core_mem_bridge #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                reset,
    z_core_mem_bridge_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD, RMW_RD, RMW_WR, WR, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic              uns_q, uns_d;
    logic [1:0]        lo_q, lo_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              ready_q, ready_d;
    logic              err_q, err_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;

    logic              bad_access;
    logic              in_mem;
    logic [4:0]        shamt;
    logic [31:0]       lane_mask;
    logic [31:0]       shifted;
    logic [31:0]       extracted;
    logic [31:0]       merged;

    assign bad_access = (bus.core_size == 2'b11) ||
                        (bus.core_size == 2'b01 && bus.core_addr[0]) ||
                        (bus.core_size == 2'b10 && bus.core_addr[1:0] != 2'b00);
    assign in_mem = (state_q == RD) || (state_q == RMW_RD) ||
                    (state_q == RMW_WR) || (state_q == WR);

    // Lane shift/mask derived from the latched access, shared by load extract and store merge.
    always_comb begin
        shamt     = 5'd0;
        lane_mask = 32'hFFFF_FFFF;
        if (size_q == 2'b00) begin
            shamt     = {lo_q, 3'b000};
            lane_mask = 32'h0000_00FF << shamt;
        end else if (size_q == 2'b01) begin
            shamt     = {lo_q[1], 4'b0000};
            lane_mask = 32'h0000_FFFF << shamt;
        end
        shifted = bus.mem_rdata >> shamt;
        case (size_q)
            2'b00:   extracted = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   extracted = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
            default: extracted = shifted;
        endcase
        merged = (bus.mem_rdata & ~lane_mask) | ((wdata_q << shamt) & lane_mask);
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lo_d        = lo_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.core_req) begin
                    size_d     = bus.core_size;
                    uns_d      = bus.core_unsigned;
                    lo_d       = bus.core_addr[1:0];
                    wdata_d    = bus.core_wdata;
                    mem_addr_d = {bus.core_addr[31:2], 2'b00};
                    rdata_d    = 32'd0;
                    cnt_d      = '0;
                    if (bad_access) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else if (!bus.core_we) begin
                        state_d = RD;
                    end else if (bus.core_size == 2'b10) begin
                        state_d     = WR;
                        mem_wdata_d = bus.core_wdata;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            RD: if (bus.mem_ack) begin
                rdata_d = extracted;
                state_d = DONE;
            end
            RMW_RD: if (bus.mem_ack) begin
                mem_wdata_d = merged;
                cnt_d       = '0;
                state_d     = RMW_WR;
            end
            RMW_WR, WR: if (bus.mem_ack) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // A stalled request gives up once TIMEOUT_CYCLES cycles pass without ack.
        if (in_mem && !bus.mem_ack) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(TIMEOUT_CYCLES)) begin
                state_d = DONE;
                err_d   = 1'b1;
            end
        end
        ready_d   = (state_d == DONE);
        mem_req_d = (state_d == RD) || (state_d == RMW_RD) ||
                    (state_d == RMW_WR) || (state_d == WR);
        mem_we_d  = (state_d == RMW_WR) || (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            lo_q        <= 2'b00;
            wdata_q     <= 32'd0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lo_q        <= lo_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
        end
    end

    assign bus.core_rdata = rdata_q;
    assign bus.core_ready = ready_q;
    assign bus.core_err   = err_q;
    assign bus.mem_req    = mem_req_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_z_core_mem_bridge.sv
// Directed bench for z_core_mem_bridge with a small ack-delay memory responder.
module tb_z_core_mem_bridge;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    z_core_mem_bridge_if bus();

    z_core_mem_bridge #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          errors = 0;
    int          checks = 0;
    logic        ack_en;
    int          ack_wait;
    int          wcnt = 0;
    logic [31:0] mem_word;
    int          wr_cnt = 0;
    logic [31:0] last_wdata = 32'd0;
    logic [31:0] last_waddr = 32'd0;
    logic [31:0] last_raddr = 32'd0;

    assign bus.mem_ack   = ack_en && bus.mem_req && (wcnt >= ack_wait);
    assign bus.mem_rdata = mem_word;

    always @(posedge clk) begin
        wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
        if (bus.mem_req && bus.mem_ack && bus.mem_we) begin
            wr_cnt     <= wr_cnt + 1;
            last_wdata <= bus.mem_wdata;
            last_waddr <= bus.mem_addr;
        end
        if (bus.mem_req && bus.mem_ack && !bus.mem_we) last_raddr <= bus.mem_addr;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_op(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int lat, output int reqc,
                         output logic [31:0] rd, output logic er);
        @(negedge clk);
        bus.core_req      = 1'b1;
        bus.core_we       = we;
        bus.core_size     = sz;
        bus.core_unsigned = uns;
        bus.core_addr     = a;
        bus.core_wdata    = wd;
        @(posedge clk);
        @(negedge clk);
        bus.core_req = 1'b0;
        lat  = 0;
        reqc = 0;
        for (int c = 1; c <= 40; c++) begin
            if (bus.mem_req) reqc++;
            if (bus.core_ready) begin
                lat = c;
                break;
            end
            @(negedge clk);
        end
        rd = bus.core_rdata;
        er = bus.core_err;
    endtask

    int          lat, reqc, wr_before;
    logic [31:0] rd;
    logic        er;

    initial begin
        reset = 1'b0;
        ack_en = 1'b1;
        ack_wait = 0;
        mem_word = 32'd0;
        bus.core_req = 1'b0;
        bus.core_we = 1'b0;
        bus.core_size = 2'b00;
        bus.core_unsigned = 1'b0;
        bus.core_addr = 32'd0;
        bus.core_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, bus.core_ready}, 32'd0);
        chk("rst_err", {31'd0, bus.core_err}, 32'd0);
        chk("rst_rdata", bus.core_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        chk("rst_mem_addr", bus.mem_addr, 32'd0);
        reset = 1'b1;

        // LW zero-wait
        mem_word = 32'hDEADBEEF;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("lw_lat", 32'(lat), 32'd2);
        chk("lw_rdata", rd, 32'hDEADBEEF);
        chk("lw_err", {31'd0, er}, 32'd0);
        chk("lw_addr", last_raddr, 32'h100);

        // Byte / half loads with extension
        mem_word = 32'h80123456;
        do_op(1'b0, 2'b00, 1'b0, 32'h103, 32'd0, lat, reqc, rd, er);
        chk("lb_rdata", rd, 32'hFFFFFF80);
        chk("lb_addr", last_raddr, 32'h100);
        do_op(1'b0, 2'b00, 1'b1, 32'h103, 32'd0, lat, reqc, rd, er);
        chk("lbu_rdata", rd, 32'h00000080);
        do_op(1'b0, 2'b01, 1'b0, 32'h102, 32'd0, lat, reqc, rd, er);
        chk("lh_hi_rdata", rd, 32'hFFFF8012);
        mem_word = 32'h1234F00D;
        do_op(1'b0, 2'b01, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("lh_lo_rdata", rd, 32'hFFFFF00D);
        do_op(1'b0, 2'b01, 1'b1, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("lhu_lo_rdata", rd, 32'h0000F00D);
        do_op(1'b0, 2'b00, 1'b0, 32'h101, 32'd0, lat, reqc, rd, er);
        chk("lb_b1_rdata", rd, 32'hFFFFFFF0);

        // Sub-word stores via RMW
        mem_word = 32'h11223344;
        wr_before = wr_cnt;
        do_op(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000AB, lat, reqc, rd, er);
        chk("sb_lat", 32'(lat), 32'd3);
        chk("sb_err", {31'd0, er}, 32'd0);
        chk("sb_wcnt", 32'(wr_cnt - wr_before), 32'd1);
        chk("sb_wdata", last_wdata, 32'h11AB3344);
        chk("sb_waddr", last_waddr, 32'h200);
        do_op(1'b1, 2'b01, 1'b0, 32'h202, 32'hFFFFBEEF, lat, reqc, rd, er);
        chk("sh_wdata", last_wdata, 32'hBEEF3344);

        // Word store
        do_op(1'b1, 2'b10, 1'b0, 32'h300, 32'hCAFEF00D, lat, reqc, rd, er);
        chk("sw_lat", 32'(lat), 32'd2);
        chk("sw_wdata", last_wdata, 32'hCAFEF00D);
        chk("sw_waddr", last_waddr, 32'h300);

        // Alignment / size errors
        wr_before = wr_cnt;
        do_op(1'b1, 2'b01, 1'b0, 32'h201, 32'h1234, lat, reqc, rd, er);
        chk("sh_mis_lat", 32'(lat), 32'd1);
        chk("sh_mis_err", {31'd0, er}, 32'd1);
        chk("sh_mis_req", 32'(reqc), 32'd0);
        chk("sh_mis_nowr", 32'(wr_cnt - wr_before), 32'd0);
        do_op(1'b0, 2'b10, 1'b0, 32'h102, 32'd0, lat, reqc, rd, er);
        chk("lw_mis_err", {31'd0, er}, 32'd1);
        chk("lw_mis_rdata", rd, 32'd0);
        chk("lw_mis_req", 32'(reqc), 32'd0);
        do_op(1'b0, 2'b11, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("sz11_lat_err", {lat[30:0], er}, {31'd1, 1'b1});

        // Waited ack just inside the timeout
        mem_word = 32'h0BADF00D;
        ack_wait = 3;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("lw_w3_lat", 32'(lat), 32'd5);
        chk("lw_w3_err", {31'd0, er}, 32'd0);
        chk("lw_w3_rdata", rd, 32'h0BADF00D);
        ack_wait = 0;

        // Load timeout
        ack_en = 1'b0;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("to_lat", 32'(lat), 32'd5);
        chk("to_req_cycles", 32'(reqc), 32'd4);
        chk("to_err", {31'd0, er}, 32'd1);
        chk("to_rdata", rd, 32'd0);

        // RMW timeout leaves memory untouched
        wr_before = wr_cnt;
        do_op(1'b1, 2'b00, 1'b0, 32'h202, 32'h55, lat, reqc, rd, er);
        chk("rmw_to_err", {31'd0, er}, 32'd1);
        chk("rmw_to_nowr", 32'(wr_cnt - wr_before), 32'd0);

        // Reset in the middle of RMW_RD
        @(negedge clk);
        bus.core_req = 1'b1;
        bus.core_we = 1'b1;
        bus.core_size = 2'b00;
        bus.core_addr = 32'h202;
        bus.core_wdata = 32'hAB;
        @(posedge clk);
        @(negedge clk);
        bus.core_req = 1'b0;
        chk("mid_req_on", {31'd0, bus.mem_req}, 32'd1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
        chk("mid_rst_ready", {31'd0, bus.core_ready}, 32'd0);
        reset = 1'b1;
        ack_en = 1'b1;
        @(negedge clk);
        chk("mid_rst_ready2", {31'd0, bus.core_ready}, 32'd0);
        chk("mid_rst_nowr", 32'(wr_cnt - wr_before), 32'd0);
        mem_word = 32'hDEADBEEF;
        do_op(1'b0, 2'b10, 1'b0, 32'h100, 32'd0, lat, reqc, rd, er);
        chk("post_rst_lat", 32'(lat), 32'd2);
        chk("post_rst_rdata", rd, 32'hDEADBEEF);
        chk("post_rst_err", {31'd0, er}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
